// File: rtl/alu_issue_stage.sv
// ALU issue stage: decodes op class/funct fields into a 4-bit ALU control code,
// selects operand B and buffers {A, B, control, illegal} in a 2-entry FIFO.
module alu_issue_stage #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_flush,
    input  logic            i_in_valid,
    output logic            o_in_ready,
    input  logic [1:0]      i_alu_op,
    input  logic [2:0]      i_funct3,
    input  logic            i_funct7_5,
    input  logic            i_alu_src,
    input  logic [XLEN-1:0] i_rs1_data,
    input  logic [XLEN-1:0] i_rs2_data,
    input  logic [XLEN-1:0] i_imm,
    output logic            o_out_valid,
    input  logic            i_out_ready,
    output logic [XLEN-1:0] o_a,
    output logic [XLEN-1:0] o_b,
    output logic [3:0]      o_control,
    output logic            o_illegal,
    output logic            o_illegal_seen
);

    localparam int unsigned CTRL_W = 4;
    localparam int unsigned CNT_W  = 2;
    localparam logic [CNT_W-1:0]  FULL     = CNT_W'(DEPTH);
    localparam logic [CTRL_W-1:0] CTRL_AND = 4'b0000;
    localparam logic [CTRL_W-1:0] CTRL_OR  = 4'b0001;
    localparam logic [CTRL_W-1:0] CTRL_ADD = 4'b0010;
    localparam logic [CTRL_W-1:0] CTRL_SUB = 4'b0110;
    localparam logic [CTRL_W-1:0] CTRL_ILL = 4'b1111;

    typedef struct packed {
        logic [XLEN-1:0]   a;
        logic [XLEN-1:0]   b;
        logic [CTRL_W-1:0] control;
        logic              illegal;
    } entry_t;

    entry_t           r_mem [0:1];
    logic             r_wr_ptr;
    logic             r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             r_in_ready;
    logic             r_out_valid;
    logic             r_illegal_seen;

    entry_t           w_entry;
    logic             w_push;
    logic             w_pop;
    logic [CNT_W-1:0] w_count_nxt;

    // Decode the incoming operation into a FIFO entry.
    always_comb begin
        w_entry         = '0;
        w_entry.a       = i_rs1_data;
        w_entry.b       = i_alu_src ? i_imm : i_rs2_data;
        w_entry.control = CTRL_ADD;
        w_entry.illegal = 1'b0;
        case (i_alu_op)
            2'b00: w_entry.control = CTRL_ADD;
            2'b01: w_entry.control = CTRL_SUB;
            2'b10: begin
                case (i_funct3)
                    3'b000:  w_entry.control = (i_funct7_5 && !i_alu_src) ? CTRL_SUB : CTRL_ADD;
                    3'b111:  w_entry.control = CTRL_AND;
                    3'b110:  w_entry.control = CTRL_OR;
                    default: w_entry.illegal = 1'b1;
                endcase
            end
            default: w_entry.illegal = 1'b1;
        endcase
        if (w_entry.illegal) begin
            w_entry.control = CTRL_ILL;
        end
    end

    assign w_push = i_in_valid && r_in_ready;
    assign w_pop  = r_out_valid && i_out_ready;

    always_comb begin
        w_count_nxt = r_count;
        if (w_push && !w_pop) begin
            w_count_nxt = r_count + CNT_W'(1);
        end else if (!w_push && w_pop) begin
            w_count_nxt = r_count - CNT_W'(1);
        end
    end

    // FIFO storage, pointers and registered handshake flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr       <= 1'b0;
            r_rd_ptr       <= 1'b0;
            r_count        <= '0;
            r_in_ready     <= 1'b1;
            r_out_valid    <= 1'b0;
            r_illegal_seen <= 1'b0;
        end else if (i_flush) begin
            r_wr_ptr    <= 1'b0;
            r_rd_ptr    <= 1'b0;
            r_count     <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= w_entry;
                r_wr_ptr        <= ~r_wr_ptr;
                if (w_entry.illegal) begin
                    r_illegal_seen <= 1'b1;
                end
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_count     <= w_count_nxt;
            r_in_ready  <= (w_count_nxt != FULL);
            r_out_valid <= (w_count_nxt != '0);
        end
    end

    assign o_in_ready     = r_in_ready;
    assign o_out_valid    = r_out_valid;
    assign o_a            = r_mem[r_rd_ptr].a;
    assign o_b            = r_mem[r_rd_ptr].b;
    assign o_control      = r_mem[r_rd_ptr].control;
    assign o_illegal      = r_mem[r_rd_ptr].illegal;
    assign o_illegal_seen = r_illegal_seen;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Self-checking bench for alu_issue_stage: directed vector table, hand-written
// backpressure/flush/reset sequences and randomized traffic against a queue model.
module tb_alu_issue_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  alu_op;
    logic [2:0]  funct3;
    logic        funct7_5;
    logic        alu_src;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [31:0] imm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] a_o;
    logic [31:0] b_o;
    logic [3:0]  control;
    logic        illegal;
    logic        illegal_seen;

    alu_issue_stage #(.XLEN(32), .DEPTH(2)) dut (
        .clk            (clk),
        .rst            (rst),
        .i_flush        (flush),
        .i_in_valid     (in_valid),
        .o_in_ready     (in_ready),
        .i_alu_op       (alu_op),
        .i_funct3       (funct3),
        .i_funct7_5     (funct7_5),
        .i_alu_src      (alu_src),
        .i_rs1_data     (rs1_data),
        .i_rs2_data     (rs2_data),
        .i_imm          (imm),
        .o_out_valid    (out_valid),
        .i_out_ready    (out_ready),
        .o_a            (a_o),
        .o_b            (b_o),
        .o_control      (control),
        .o_illegal      (illegal),
        .o_illegal_seen (illegal_seen)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]  op;
        logic [2:0]  f3;
        logic        f7;
        logic        src;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [31:0] im;
    } stim_t;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  ctrl;
        logic        ill;
    } exp_t;

    typedef struct packed {
        stim_t       s;
        logic [3:0]  ctrl;
        logic        ill;
        logic [31:0] b;
    } vec_t;

    int   n_tests = 0;
    int   n_fail  = 0;
    exp_t exp_q[$];
    logic seen_m = 1'b0;
    logic [3:0] pop_log[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference decode straight from the op-class rules; returns {illegal, control}.
    function automatic logic [4:0] ref_dec(input stim_t s);
        if (s.op == 2'd0) return 5'b0_0010;
        if (s.op == 2'd1) return 5'b0_0110;
        if (s.op == 2'd3) return 5'b1_1111;
        if (s.f3 == 3'd0) return (s.f7 && !s.src) ? 5'b0_0110 : 5'b0_0010;
        if (s.f3 == 3'd7) return 5'b0_0000;
        if (s.f3 == 3'd6) return 5'b0_0001;
        return 5'b1_1111;
    endfunction

    function automatic stim_t rand_stim();
        stim_t s;
        s.op  = 2'($urandom_range(0, 3));
        s.f3  = 3'($urandom_range(0, 7));
        s.f7  = 1'($urandom_range(0, 1));
        s.src = 1'($urandom_range(0, 1));
        s.rs1 = $urandom;
        s.rs2 = $urandom;
        s.im  = $urandom;
        return s;
    endfunction

    // One clock cycle: check outputs against the model, drive, clock, update model.
    task automatic step(input logic fl, input logic iv, input logic ordy, input stim_t s);
        logic [4:0] d;
        exp_t e;
        bit   do_push;
        bit   do_pop;
        chk("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
        chk("in_ready", 32'(in_ready), 32'(exp_q.size() < 2));
        if (exp_q.size() != 0) begin
            chk("A", a_o, exp_q[0].a);
            chk("B", b_o, exp_q[0].b);
            chk("control", 32'(control), 32'(exp_q[0].ctrl));
            chk("illegal", 32'(illegal), 32'(exp_q[0].ill));
        end
        chk("illegal_seen", 32'(illegal_seen), 32'(seen_m));
        if (out_valid && ordy) pop_log.push_back(control);
        flush    = fl;
        in_valid = iv;
        out_ready = ordy;
        alu_op   = s.op;
        funct3   = s.f3;
        funct7_5 = s.f7;
        alu_src  = s.src;
        rs1_data = s.rs1;
        rs2_data = s.rs2;
        imm      = s.im;
        do_push  = iv && (exp_q.size() < 2);
        do_pop   = ordy && (exp_q.size() != 0);
        @(posedge clk);
        if (fl) begin
            exp_q.delete();
        end else begin
            if (do_pop) void'(exp_q.pop_front());
            if (do_push) begin
                d      = ref_dec(s);
                e.a    = s.rs1;
                e.b    = s.src ? s.im : s.rs2;
                e.ctrl = d[3:0];
                e.ill  = d[4];
                exp_q.push_back(e);
                if (d[4]) seen_m = 1'b1;
            end
        end
        @(negedge clk);
    endtask

    function automatic stim_t mk(input logic [1:0] op, input logic [2:0] f3, input logic f7,
                                 input logic src, input logic [31:0] r1, input logic [31:0] r2,
                                 input logic [31:0] im);
        stim_t s;
        s.op = op; s.f3 = f3; s.f7 = f7; s.src = src; s.rs1 = r1; s.rs2 = r2; s.im = im;
        return s;
    endfunction

    vec_t  vecs[9];
    stim_t idle;

    initial begin
        idle = '0;
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        alu_op = '0; funct3 = '0; funct7_5 = 1'b0; alu_src = 1'b0;
        rs1_data = '0; rs2_data = '0; imm = '0;

        vecs[0] = '{mk(2'b10, 3'b000, 1'b1, 1'b0, 32'd7, 32'd3, 32'd0), 4'b0110, 1'b0, 32'd3};
        vecs[1] = '{mk(2'b10, 3'b000, 1'b1, 1'b1, 32'd5, 32'd9, 32'hFFFF_FFFC), 4'b0010, 1'b0, 32'hFFFF_FFFC};
        vecs[2] = '{mk(2'b10, 3'b000, 1'b0, 1'b0, 32'd1, 32'd2, 32'd4), 4'b0010, 1'b0, 32'd2};
        vecs[3] = '{mk(2'b10, 3'b111, 1'b0, 1'b0, 32'hF0F0, 32'h0FF0, 32'd0), 4'b0000, 1'b0, 32'h0FF0};
        vecs[4] = '{mk(2'b10, 3'b110, 1'b1, 1'b1, 32'h11, 32'h22, 32'h33), 4'b0001, 1'b0, 32'h33};
        vecs[5] = '{mk(2'b00, 3'b010, 1'b0, 1'b1, 32'h100, 32'h5, 32'h40), 4'b0010, 1'b0, 32'h40};
        vecs[6] = '{mk(2'b01, 3'b001, 1'b1, 1'b0, 32'hA, 32'hB, 32'hC), 4'b0110, 1'b0, 32'hB};
        vecs[7] = '{mk(2'b11, 3'b000, 1'b0, 1'b0, 32'h1, 32'h2, 32'h3), 4'b1111, 1'b1, 32'h2};
        vecs[8] = '{mk(2'b10, 3'b001, 1'b0, 1'b1, 32'h4, 32'h5, 32'h6), 4'b1111, 1'b1, 32'h6};

        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        chk("rst out_valid", 32'(out_valid), 32'd0);
        chk("rst in_ready", 32'(in_ready), 32'd1);
        chk("rst A", a_o, 32'd0);
        chk("rst B", b_o, 32'd0);
        chk("rst control", 32'(control), 32'd0);
        chk("rst illegal", 32'(illegal), 32'd0);
        chk("rst illegal_seen", 32'(illegal_seen), 32'd0);

        // Directed decode table: push one entry, check it next cycle, drain it.
        for (int i = 0; i < 9; i++) begin
            step(1'b0, 1'b1, 1'b1, vecs[i].s);
            chk("vec out_valid", 32'(out_valid), 32'd1);
            chk("vec A", a_o, vecs[i].s.rs1);
            chk("vec B", b_o, vecs[i].b);
            chk("vec control", 32'(control), 32'(vecs[i].ctrl));
            chk("vec illegal", 32'(illegal), 32'(vecs[i].ill));
            step(1'b0, 1'b0, 1'b1, idle);
        end
        chk("illegal_seen set", 32'(illegal_seen), 32'd1);

        // Backpressure: three pushes with out_ready low, third held upstream.
        pop_log.delete();
        step(1'b0, 1'b1, 1'b0, mk(2'b10, 3'b111, 1'b0, 1'b0, 32'd1, 32'd2, 32'd0));
        step(1'b0, 1'b1, 1'b0, mk(2'b10, 3'b110, 1'b0, 1'b0, 32'd3, 32'd4, 32'd0));
        chk("full in_ready", 32'(in_ready), 32'd0);
        step(1'b0, 1'b1, 1'b0, mk(2'b00, 3'b000, 1'b0, 1'b0, 32'd5, 32'd6, 32'd0));
        step(1'b0, 1'b1, 1'b1, mk(2'b00, 3'b000, 1'b0, 1'b0, 32'd5, 32'd6, 32'd0));
        step(1'b0, 1'b1, 1'b1, mk(2'b00, 3'b000, 1'b0, 1'b0, 32'd5, 32'd6, 32'd0));
        step(1'b0, 1'b0, 1'b1, idle);
        step(1'b0, 1'b0, 1'b1, idle);
        chk("bp pop count", 32'(pop_log.size()), 32'd3);
        if (pop_log.size() == 3) begin
            chk("bp order 0", 32'(pop_log[0]), 32'h0);
            chk("bp order 1", 32'(pop_log[1]), 32'h1);
            chk("bp order 2", 32'(pop_log[2]), 32'h2);
        end

        // Steady streaming at count=1 with simultaneous push and pop.
        step(1'b0, 1'b1, 1'b0, rand_stim());
        for (int i = 0; i < 10; i++) begin
            chk("stream in_ready", 32'(in_ready), 32'd1);
            chk("stream out_valid", 32'(out_valid), 32'd1);
            step(1'b0, 1'b1, 1'b1, rand_stim());
        end
        step(1'b0, 1'b0, 1'b1, idle);

        // Flush with two entries (and a push on the flush edge).
        step(1'b0, 1'b1, 1'b0, rand_stim());
        step(1'b0, 1'b1, 1'b0, rand_stim());
        step(1'b1, 1'b1, 1'b1, rand_stim());
        chk("flush out_valid", 32'(out_valid), 32'd0);
        chk("flush in_ready", 32'(in_ready), 32'd1);
        chk("flush keeps seen", 32'(illegal_seen), 32'd1);

        // Async reset mid-cycle with entries present.
        step(1'b0, 1'b1, 1'b0, rand_stim());
        step(1'b0, 1'b1, 1'b0, rand_stim());
        in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("async rst out_valid", 32'(out_valid), 32'd0);
        chk("async rst in_ready", 32'(in_ready), 32'd1);
        chk("async rst seen", 32'(illegal_seen), 32'd0);
        exp_q.delete();
        seen_m = 1'b0;
        @(negedge clk);
        rst = 1'b0;

        // Randomized traffic against the queue model.
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 31) == 0), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), rand_stim());
        end
        step(1'b0, 1'b0, 1'b1, idle);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
- Producer side of the ALU operand/control interface: decodes main-decoder ALU op class plus funct fields into the 4-bit ALU control code.
- Selects operand B (register or immediate) and buffers {A, B, control, illegal} in a 2-entry FIFO with valid/ready handshakes on both sides.
- Sits between the decode stage and the ALU; decouples decode from ALU/writeback stalls.

Parameters:
- XLEN, 32, operand width.
- DEPTH, 2, FIFO entries; fixed at 2; other values unsupported.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- flush  in  1  synchronous; discards all buffered entries.
- in_valid  in  1  decode has an operation.
- in_ready  out  1  stage can accept this cycle.
- alu_op  in  2  op class: 00 load/store, 01 branch, 10 R/I arithmetic, 11 reserved.
- funct3  in  3  instruction funct3.
- funct7_5  in  1  instruction bit 30.
- alu_src  in  1  1 = B from imm, 0 = B from rs2_data.
- rs1_data  in  XLEN  operand A source.
- rs2_data  in  XLEN  register operand B source.
- imm  in  XLEN  sign-extended immediate.
- out_valid  out  1  head entry valid toward ALU.
- out_ready  in  1  ALU consumes head this cycle.
- A  out  XLEN  head operand A.
- B  out  XLEN  head operand B.
- control  out  4  head ALU control code.
- illegal  out  1  head entry has an undecodable op.
- illegal_seen  out  1  sticky; set when an illegal op is accepted.

Behaviour:
- Reset (async, rst=1): FIFO count=0, read/write pointers=0, out_valid=0, in_ready=1, illegal_seen=0. A, B, control and illegal read 0.
- Decode is combinational at accept time.
  - alu_op=00 -> 0010 (ADD).
  - alu_op=01 -> 0110 (SUB).
  - alu_op=10:
    - funct3=000 -> 0110 if funct7_5=1 and alu_src=0, else 0010.
    - funct3=111 -> 0000 (AND).
    - funct3=110 -> 0001 (OR).
    - any other funct3 -> illegal.
  - alu_op=11 -> illegal.
  - Illegal entries carry control=1111 and illegal=1.
- B = alu_src ? imm : rs2_data. A = rs1_data. No arithmetic is performed here.
- Push occurs when in_valid & in_ready. Pop occurs when out_valid & out_ready.
- in_ready = (count != 2). It is derived from registered count only and never depends on out_ready.
- out_valid = (count != 0). Outputs show the head entry and are stable while out_valid & !out_ready.
- Latency: an entry accepted at edge N appears on the outputs after edge N, so it is consumable in cycle N+1. There is no combinational input-to-output path.
- Order is strictly FIFO. Pointers are 1 bit and wrap 1->0.
- Boundary cases:
  - count=0 with push: count -> 1; there is no bypass.
  - count=1 with push and pop on the same edge: count stays 1 and the new entry becomes head.
  - count=2: in_ready=0, so no push. Pop brings count to 1, and in_ready=1 on the next cycle.
  - Pop with count=0: impossible, since out_valid=0.
- flush=1 at an edge: count=0, pointers=0, and any push or pop on that edge is ignored. out_valid=0 and in_ready=1 the next cycle. illegal_seen is not cleared by flush.
- illegal_seen sets on any push with a decoded illegal op. It clears only on rst.
- rst asserted mid-transfer: all entries are lost immediately; the upstream must re-issue.

Test Plan:
- Reset then push alu_op=10, funct3=000, funct7_5=1, alu_src=0, rs1=7, rs2=3, with out_ready=1 -> next cycle out_valid=1, A=7, B=3, control=0110, illegal=0.
- Push alu_op=10, funct3=000, funct7_5=1, alu_src=1, imm=0xFFFFFFFC -> control=0010 (ADDI, not SUB), B=0xFFFFFFFC.
- Hold out_ready=0 and push 3 ops back-to-back (AND, OR, ADD) -> in_ready=0 after the 2nd accept and the 3rd is held upstream. Raise out_ready -> outputs 0000, 0001, 0010 in order, with no loss or duplication.
- count=1 with simultaneous push and pop for 10 cycles at out_ready=1 -> one output per cycle, count steady at 1, in_ready stays 1.
- Push alu_op=11, then alu_op=10 with funct3=001 -> both delivered with control=1111 and illegal=1; illegal_seen=1 and stays 1 after flush.
- Fill to 2 entries, assert flush -> next cycle out_valid=0 and in_ready=1. Assert rst asynchronously mid-cycle with entries present -> out_valid drops immediately without waiting for a clock edge.
